// File: rtl/complex_unmix.sv
// rtl/complex_unmix.sv - inverse of the o0..o7 mixing round, one word update per cycle
module complex_unmix #(
    parameter int ROUNDS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, LOAD, UNC, UNB, UNA, EMIT} state_t;

    localparam logic [7:0] LAST_RND = 8'(ROUNDS - 1);

    state_t      state, state_next;
    logic [31:0] o [8];
    logic [2:0]  idx, idx_next, wr_idx;
    logic [7:0]  rnd, rnd_next;
    logic        live;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [31:0] cur, p1, p2, p3, p4, p5;
    logic        in_fire;

    assign cur = o[idx];
    assign p1  = o[idx + 3'd1];
    assign p2  = o[idx + 3'd2];
    assign p3  = o[idx + 3'd3];
    assign p4  = o[idx + 3'd4];
    assign p5  = o[idx + 3'd5];

    // live keeps in_ready low until the first edge after reset release
    assign in_ready  = live && (state == IDLE || state == LOAD);
    assign in_fire   = in_valid && in_ready;
    assign out_valid = (state == EMIT);
    assign out_data  = (state == EMIT) ? cur : 32'd0;
    assign out_last  = (state == EMIT) && (idx == 3'd7);
    assign busy      = (state != IDLE);

    always_comb begin
        state_next = state;
        idx_next   = idx;
        rnd_next   = rnd;
        wr_en      = 1'b0;
        wr_idx     = idx;
        wr_data    = cur;
        case (state)
            IDLE: begin
                wr_idx = 3'd0;
                if (in_fire) begin
                    wr_en      = 1'b1;
                    wr_data    = in_data;
                    idx_next   = 3'd1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (in_fire) begin
                    wr_en   = 1'b1;
                    wr_data = in_data;
                    if (idx == 3'd7) begin
                        idx_next   = 3'd7;
                        rnd_next   = 8'd0;
                        state_next = UNC;
                    end else begin
                        idx_next = idx + 3'd1;
                    end
                end
            end
            UNC: begin
                wr_en    = 1'b1;
                wr_data  = cur + (p2 >> 17) - (p4 >> 12);
                idx_next = idx - 3'd1;
                if (idx == 3'd0) begin
                    idx_next   = 3'd7;
                    state_next = UNB;
                end
            end
            UNB: begin
                wr_en    = 1'b1;
                wr_data  = cur ^ (p3 << 16);
                idx_next = idx - 3'd1;
                if (idx == 3'd0) begin
                    idx_next   = 3'd7;
                    state_next = UNA;
                end
            end
            UNA: begin
                wr_en    = 1'b1;
                wr_data  = cur - p1 + p5;
                idx_next = idx - 3'd1;
                if (idx == 3'd0) begin
                    if (rnd == LAST_RND) begin
                        idx_next   = 3'd0;
                        state_next = EMIT;
                    end else begin
                        rnd_next   = rnd + 8'd1;
                        idx_next   = 3'd7;
                        state_next = UNC;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    idx_next = idx + 3'd1;
                    if (idx == 3'd7) begin
                        idx_next   = 3'd0;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= 3'd0;
            rnd   <= 8'd0;
            live  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                o[i] <= 32'd0;
            end
        end else begin
            state <= state_next;
            idx   <= idx_next;
            rnd   <= rnd_next;
            live  <= 1'b1;
            if (wr_en) begin
                o[wr_idx] <= wr_data;
            end
        end
    end

endmodule

// File: doc/complex_unmix.md
# complex_unmix

Inverse of the eight-word `o0..o7` mixing round used by the complex-op benchmarks. The block accepts a mixed 8×32-bit state as a word stream and undoes `ROUNDS` forward rounds, one word update per cycle. It returns the recovered pre-mix state as a word stream. It sits downstream of the mixer so that benches can round-trip check the forward datapath.

## Interface
- `ROUNDS`, default 8: number of forward rounds to undo. Legal range is 1..255.
- `clk` input, 1 bit: the single clock; all state changes on posedge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `in_valid` input, 1 bit: `in_data` holds a state word.
- `in_ready` output, 1 bit: block accepts a word this cycle.
- `in_data` input, 32 bits: state word. Words arrive in order `o0` first, `o7` last.
- `out_valid` output, 1 bit: `out_data` holds a recovered word.
- `out_ready` input, 1 bit: downstream accepts the word.
- `out_data` output, 32 bits: recovered word. Words leave in order `o0` first, `o7` last.
- `out_last` output, 1 bit: high together with `out_valid` on word `o7`.
- `busy` output, 1 bit: high in every state except IDLE.

## Operation
- **Forward round definition.** All updates are in place and sequential. Indices are mod 8. Arithmetic is mod 2^32, and shifts are logical.
  - Pass A, for i = 0..7: `o[i] = o[i] + o[i+1] - o[i+5]`
  - Pass B, for i = 0..7: `o[i] = o[i] ^ (o[i+3] << 16)`
  - Pass C, for i = 0..7: `o[i] = o[i] - (o[i+2] >> 17) + (o[i+4] >> 12)`
- **Inverse round.** Passes run in reverse order, and each pass runs i = 7 down to 0.
  - Undo C: `o[i] = o[i] + (o[i+2] >> 17) - (o[i+4] >> 12)`
  - Undo B: `o[i] = o[i] ^ (o[i+3] << 16)`
  - Undo A: `o[i] = o[i] - o[i+1] + o[i+5]`
- **Datapath.** Eight 32-bit registers, a 3-bit word index `idx`, and an 8-bit round counter `rnd`. Exactly one register is written per compute cycle.
- **FSM states:** IDLE, LOAD, UNC, UNB, UNA, EMIT.
  - **IDLE:** `in_ready` = 1. An accepted word is written to `o[0]`; set `idx` = 1 and go to LOAD.
  - **LOAD:** `in_ready` = 1. Each accepted word is written to `o[idx]` and `idx` increments. Acceptance with `idx` = 7 sets `idx` = 7, `rnd` = 0 and goes to UNC. Cycles where `in_valid` is low leave the state unchanged.
  - **UNC:** apply Undo C to `o[idx]` and decrement `idx`. When `idx` = 0, set `idx` = 7 and go to UNB.
  - **UNB:** same stepping as UNC, applying Undo B. When `idx` = 0, go to UNA.
  - **UNA:** same stepping, applying Undo A. When `idx` = 0:
    - if `rnd` = `ROUNDS` − 1, set `idx` = 0 and go to EMIT;
    - otherwise `rnd` increments, set `idx` = 7 and go to UNC.
  - **EMIT:** `out_valid` = 1 and `out_data` = `o[idx]`. On `out_ready`, `idx` increments. Handshake on `idx` = 7 returns to IDLE.
- **Handshake rules.**
  - A word transfers only on a cycle where valid and ready are both high.
  - `out_valid`, `out_data` and `out_last` hold stable while `out_ready` is low.
  - `out_valid` never deasserts without a transfer.
  - `in_ready` = 0 in the UNC, UNB, UNA and EMIT states.

## Timing
- **Reset values:**
  - `in_ready` = 0 during reset, and 1 from the first cycle after `rst_n` rises (IDLE).
  - `out_valid` = 0, `out_last` = 0, `out_data` = 0, `busy` = 0.
  - All state registers = 0, `idx` = 0, `rnd` = 0, state = IDLE.
- **Latency:**
  - Load takes 8 handshake cycles.
  - Compute takes exactly 24 × `ROUNDS` cycles, with no stalls.
  - The first `out_valid` is asserted 24 × `ROUNDS` cycles after the cycle that accepted `o7`.
  - With no backpressure, EMIT takes 8 cycles.
- **Throughput:** one state per 24 × `ROUNDS` + 16 cycles when both streams run at full rate.
- **Back-to-back states:** a new state can be accepted the cycle after the `o7` output handshake; there is no overlap.
- **Reset mid-operation:** asserting `rst_n` low in any state clears everything immediately. Partial input and partial output are discarded and no output is produced.
- **Ignored inputs:**
  - `in_valid` while busy computing or emitting is ignored; its data is not consumed.
  - `out_ready` outside EMIT is ignored.

## Test plan
- **Reset:** hold `rst_n` low mid-UNB, release -> all outputs are 0, then `in_ready` = 1 one cycle later, and a fresh load works.
- **All-zero state:** `ROUNDS` = 8, input all zeros -> output is eight 0x00000000 words, `out_last` is high on the eighth word, and the first `out_valid` comes 192 cycles after the `o7` accept.
- **Known vector:** `ROUNDS` = 1, input `o7` = 0x00000001 and all other words 0 -> output `o0..o7` = 0x00030002, 0xFFFDFFFF, 0x00010000, 0x00000001, 0xFFFFFFFF, 0x00010001, 0xFFFEFFFF, 0x00010001.
- **Round-trip:** a bench forward model applies 8 rounds to a random state, seeded with values such as `o0..o7` = 0..7 -> output equals the original state. Repeat for 100 random states.
- **Backpressure:**
  - `in_valid` toggles randomly during load.
  - `out_ready` is low for 5 cycles on word 3 -> `out_data` is held stable and no words are lost or duplicated.
  - Order is `o0..o7`.
- **Back-to-back:** two states are streamed consecutively -> the second `in_ready` comes the cycle after the first `o7` output handshake, and both results are correct.
